// File: rtl/hog_block_former_if.sv
// rtl/hog_block_former_if.sv - cell stream in, 2x2 HOG block buses out
// Optional HOG_BLOCK_SOF_EN adds the i_sof start-of-frame input.
interface hog_block_former_if #(
  parameter int FEA_I     = 4,
  parameter int FEA_F     = 28,
  parameter int CELL_COLS = 80,
  parameter int CELL_ROWS = 60
);
  localparam int N  = FEA_I + FEA_F;
  localparam int W  = 9 * N;
  localparam int CW = $clog2(CELL_COLS);
  localparam int RW = $clog2(CELL_ROWS);

  logic          i_valid;
  logic [W-1:0]  i_fea;
`ifdef HOG_BLOCK_SOF_EN
  logic          i_sof;
`endif
  logic          o_valid;
  logic [W-1:0]  fea_a;
  logic [W-1:0]  fea_b;
  logic [W-1:0]  fea_c;
  logic [W-1:0]  fea_d;
  logic [CW-1:0] o_col;
  logic [RW-1:0] o_row;
  logic          o_frame_end;

  modport slave (
    input  i_valid, i_fea,
`ifdef HOG_BLOCK_SOF_EN
    input  i_sof,
`endif
    output o_valid, fea_a, fea_b, fea_c, fea_d, o_col, o_row, o_frame_end
  );

  modport master (
    output i_valid, i_fea,
`ifdef HOG_BLOCK_SOF_EN
    output i_sof,
`endif
    input  o_valid, fea_a, fea_b, fea_c, fea_d, o_col, o_row, o_frame_end
  );
endinterface

// File: rtl/hog_block_former.sv
// rtl/hog_block_former.sv - forms 2x2 blocks of HOG cells from a raster cell stream
// Optional HOG_BLOCK_SOF_EN: i_sof forces the presented cell to position (0,0).
module hog_block_former #(
  parameter int FEA_I     = 4,
  parameter int FEA_F     = 28,
  parameter int CELL_COLS = 80,
  parameter int CELL_ROWS = 60
) (
  input  logic             clk,
  input  logic             rst,
  hog_block_former_if.slave bus
);
  localparam int N  = FEA_I + FEA_F;
  localparam int W  = 9 * N;
  localparam int CW = $clog2(CELL_COLS);
  localparam int RW = $clog2(CELL_ROWS);

  logic [W-1:0]  r_linebuf [CELL_COLS];
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [W-1:0]  r_prev_cell;
  logic [W-1:0]  r_prev_top;

  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [W-1:0]  w_top;
  logic          w_last_col;
  logic          w_last_row;

`ifdef HOG_BLOCK_SOF_EN
  assign w_col = bus.i_sof ? '0 : r_col;
  assign w_row = bus.i_sof ? '0 : r_row;
`else
  assign w_col = r_col;
  assign w_row = r_row;
`endif

  // Combinational read before the clocked write gives read-first behaviour
  assign w_top      = r_linebuf[w_col];
  assign w_last_col = (w_col == CW'(CELL_COLS - 1));
  assign w_last_row = (w_row == RW'(CELL_ROWS - 1));

  always_ff @(posedge clk) begin
    if (bus.i_valid) begin
      r_linebuf[w_col] <= bus.i_fea;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col           <= '0;
      r_row           <= '0;
      r_prev_cell     <= '0;
      r_prev_top      <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_frame_end <= 1'b0;
      bus.o_col       <= '0;
      bus.o_row       <= '0;
      bus.fea_a       <= '0;
      bus.fea_b       <= '0;
      bus.fea_c       <= '0;
      bus.fea_d       <= '0;
    end else begin
      bus.o_valid     <= 1'b0;
      bus.o_frame_end <= 1'b0;
      if (bus.i_valid) begin
        r_prev_cell <= bus.i_fea;
        r_prev_top  <= w_top;
        if (w_row != '0 && w_col != '0) begin
          bus.o_valid     <= 1'b1;
          bus.o_frame_end <= w_last_col && w_last_row;
          bus.fea_a       <= r_prev_top;
          bus.fea_b       <= w_top;
          bus.fea_c       <= r_prev_cell;
          bus.fea_d       <= bus.i_fea;
          bus.o_col       <= w_col - CW'(1);
          bus.o_row       <= w_row - RW'(1);
        end
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
    end
  end
endmodule

// File: tb/tb_hog_block_former.sv
// tb/tb_hog_block_former.sv - directed self-checking bench for hog_block_former
module tb_hog_block_former;
  localparam int FI   = 4;
  localparam int FF   = 28;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int N    = FI + FF;
  localparam int W    = 9 * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hog_block_former_if #(.FEA_I(FI), .FEA_F(FF), .CELL_COLS(COLS), .CELL_ROWS(ROWS)) bus();

  hog_block_former #(.FEA_I(FI), .FEA_F(FF), .CELL_COLS(COLS), .CELL_ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;
`ifdef HOG_BLOCK_SOF_EN
  logic g_sof = 1'b0;
`endif

  function automatic logic [W-1:0] cv(input int v);
    logic [31:0] b;
    b = v;
    return {9{b}};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one cell and checks the block it should produce one cycle later
  task automatic send_cell(input int r, input int c, input int base);
    logic exp_v;
    bus.i_valid = 1'b1;
    bus.i_fea   = cv(base + r * COLS + c);
`ifdef HOG_BLOCK_SOF_EN
    bus.i_sof   = g_sof;
`endif
    @(posedge clk);
    @(negedge clk);
    exp_v = (r >= 1) && (c >= 1);
    check("o_valid", W'(bus.o_valid), W'(exp_v));
    if (bus.o_valid && exp_v) begin
      pulses++;
      check("fea_a", bus.fea_a, cv(base + (r - 1) * COLS + (c - 1)));
      check("fea_b", bus.fea_b, cv(base + (r - 1) * COLS + c));
      check("fea_c", bus.fea_c, cv(base + r * COLS + (c - 1)));
      check("fea_d", bus.fea_d, cv(base + r * COLS + c));
      check("o_col", W'(bus.o_col), W'(c - 1));
      check("o_row", W'(bus.o_row), W'(r - 1));
      check("o_frame_end", W'(bus.o_frame_end), W'((r == ROWS - 1) && (c == COLS - 1)));
    end
    bus.i_valid = 1'b0;
`ifdef HOG_BLOCK_SOF_EN
    bus.i_sof   = 1'b0;
`endif
  endtask

  task automatic idle_cycle();
    bus.i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("gap_valid", W'(bus.o_valid), W'(0));
  endtask

  task automatic run_frame(input int base, input bit gap);
    pulses = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        send_cell(r, c, base);
        if (gap) idle_cycle();
      end
    end
    check("pulse_count", W'(pulses), W'((ROWS - 1) * (COLS - 1)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, W'(bus.o_valid), W'(0));
    check({tag, "_fe"},    W'(bus.o_frame_end), W'(0));
    check({tag, "_col"},   W'(bus.o_col), W'(0));
    check({tag, "_row"},   W'(bus.o_row), W'(0));
    check({tag, "_a"},     bus.fea_a, W'(0));
    check({tag, "_b"},     bus.fea_b, W'(0));
    check({tag, "_c"},     bus.fea_c, W'(0));
    check({tag, "_d"},     bus.fea_d, W'(0));
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_fea   = '0;
`ifdef HOG_BLOCK_SOF_EN
    bus.i_sof   = 1'b0;
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    run_frame(0, 1'b0);
    run_frame(0, 1'b1);
    run_frame(0, 1'b0);
    run_frame(100, 1'b0);

    // Partial frame up to cell (1,2), then a one-cycle reset
    pulses = 0;
    for (int i = 0; i < 7; i++) send_cell(i / COLS, i % COLS, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_zero("midreset");
    run_frame(50, 1'b0);

`ifdef HOG_BLOCK_SOF_EN
    pulses = 0;
    for (int i = 0; i < 6; i++) send_cell(i / COLS, i % COLS, 0);
    pulses = 0;
    g_sof = 1'b1;
    send_cell(0, 0, 200);
    g_sof = 1'b0;
    for (int i = 1; i < ROWS * COLS; i++) send_cell(i / COLS, i % COLS, 200);
    check("sof_pulse_count", W'(pulses), W'((ROWS - 1) * (COLS - 1)));
    g_sof = 1'b1;
    send_cell(0, 0, 300);
    g_sof = 1'b0;
    for (int i = 1; i < ROWS * COLS; i++) send_cell(i / COLS, i % COLS, 300);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hog_block_former.md
Name: hog_block_former

Overview:
- Upstream feeder of the SVM parallel element.
- Takes a raster-order stream of HOG cell histograms (9 bins per cell, fixed point) and holds the previous cell row in a line buffer.
- For every cell at row ≥1 and column ≥1, emits the four cells of the 2x2 block whose bottom-right corner is that cell, as four 9-bin buses plus block coordinates.
- These buses drive the PE feature inputs (fea_a..fea_d) directly.

Parameters:
- FEA_I, 4, integer bits per bin
- FEA_F, 28, fractional bits per bin
- CELL_COLS, 80, cells per row (≥2)
- CELL_ROWS, 60, cell rows per frame (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_valid  in  1  i_fea carries one cell this cycle
- i_fea  in  9*(FEA_I+FEA_F)  cell histogram; bin k at bits [(k+1)*N-1 : k*N], where N = FEA_I+FEA_F
- o_valid  out  1  block outputs valid, one-cycle pulse per block
- fea_a  out  9*N  top-left cell (r-1, c-1)
- fea_b  out  9*N  top-right cell (r-1, c)
- fea_c  out  9*N  bottom-left cell (r, c-1)
- fea_d  out  9*N  bottom-right cell (r, c)
- o_col  out  $clog2(CELL_COLS)  block column = c-1
- o_row  out  $clog2(CELL_ROWS)  block row = r-1
- o_frame_end  out  1  high with o_valid on the last block of a frame

Behaviour:
- Reset, when rst=0 at a clk edge:
  - col_cnt, row_cnt, o_valid, o_frame_end, o_col, o_row, fea_a..d all go to 0.
  - prev_cell and prev_top registers go to 0.
  - Line buffer contents are not reset; row 0 never produces output, so stale data is never emitted.
- Per accepted cell (i_valid=1) at position (r=row_cnt, c=col_cnt):
  - top = linebuf[c], read before the same-cycle write.
  - linebuf[c] <= i_fea.
  - prev_cell <= i_fea; prev_top <= top.
- Output, registered with latency 1 cycle from the accepting edge:
  - If r≥1 and c≥1: o_valid=1, fea_a=prev_top (old value), fea_b=top, fea_c=prev_cell (old value), fea_d=i_fea, o_col=c-1, o_row=r-1.
  - Otherwise o_valid=0 and the data outputs hold their previous values.
- o_valid is 0 on any cycle following a cycle with i_valid=0. No backpressure: the consumer must accept every o_valid pulse.
- Counter wrap:
  - c==CELL_COLS-1: col_cnt→0, row_cnt increments.
  - Also r==CELL_ROWS-1: row_cnt→0, and o_frame_end=1 alongside that output.
- Blocks per frame = (CELL_ROWS-1)*(CELL_COLS-1).
- Column 0 of every row emits nothing. prev_cell/prev_top from the previous row are never used at column 0, because the output condition requires c≥1.
- i_valid gaps of any length are allowed; state holds across gaps.
- Reset mid-frame: counters return to 0, and the next accepted cell is treated as (0,0).
- Line buffer: CELL_COLS entries of 9*N bits. The read of address c must return the pre-write value. Either a register array or a RAM with read-first mode is acceptable, provided the 1-cycle latency holds.

Optional Feature:
- Macro: HOG_BLOCK_SOF_EN.
- When defined:
  - Adds input port i_sof (1 bit), meaningful only with i_valid=1.
  - The cell presented with i_sof is forced to position (0,0): counters load 0 before processing, so no output is produced for it, and counting resumes from (0,1).
  - i_sof on the cell that is already at (0,0) has no effect.
- When undefined: no i_sof port; position comes only from counters and reset.

Test Plan:
- Bench setup for all scenarios: CELL_COLS=4, CELL_ROWS=3. Cell (r,c) carries value r*4+c in every bin.
- Full frame, 12 consecutive valid cells → exactly 6 o_valid pulses. The first pulse, one cycle after cell (1,1), has a/b/c/d bin values 0/1/4/5 with o_col=0, o_row=0. The last pulse has 6/7/10/11, o_col=2, o_row=1, and o_frame_end=1; o_frame_end is 0 on all other pulses.
- Same frame with i_valid toggled 1,0,1,0,... → identical output values and order; every pulse comes exactly 1 cycle after its accepting edge.
- Two back-to-back frames (second frame value = first + 100) → the second frame's first block is 100/101/104/105; no block mixes data from both frames.
- Assert rst=0 for one cycle after cell (1,2), then send a new frame → all outputs read 0 after reset; the first post-reset pulse follows new cell (1,1).
- With HOG_BLOCK_SOF_EN: send 6 cells, then a new frame with i_sof on its first cell → that cell becomes (0,0) and the outputs match the fresh-frame scenario.
